// File: rtl/accel_seq.sv
// accel_seq: sequencer between the picoRV32 bus glue and the MNIST accelerator.
// Define ACCEL_SEQ_ARGMAX_EN to include the ARGMAX stage and the class_* outputs.
module accel_seq #(
  parameter int N_WORDS = 784,
  parameter int IDX_W   = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cmd_start,
  input  logic         cmd_clear,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [31:0]  ld_data,
  output logic         acc_reset,
  output logic [31:0]  acc_image,
  input  logic [31:0]  acc_counter1,
  input  logic         acc_ready,
  input  logic [319:0] acc_result,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_data,
  output logic [3:0]   res_idx,
  output logic         res_last,
  output logic         class_valid,
  output logic [3:0]   class_idx,
  output logic [31:0]  class_score,
  output logic         busy,
  output logic         err_timeout
);
  localparam int CYC_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0]   LD_FULL   = (IDX_W+1)'(N_WORDS);
  localparam logic [IDX_W:0]   LD_ONE    = (IDX_W+1)'(1);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(TIMEOUT - 1);
  localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
  localparam logic [CYC_W-1:0] CYC_GUARD = CYC_W'(2);
  localparam logic [31:0]      N_WORDS_W = 32'(N_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd3;
`ifdef ACCEL_SEQ_ARGMAX_EN
  localparam logic [1:0] S_ARGMAX = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [IDX_W:0]   ld_count_q, ld_count_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [319:0]     score_q, score_d;
  logic [3:0]       res_idx_q, res_idx_d;
  logic             err_q, err_d;
  logic             acc_reset_q;
  logic [31:0]      img_buf [N_WORDS];

  logic ld_fire, start_ok, acc_hit, res_fire;

`ifdef ACCEL_SEQ_ARGMAX_EN
  logic [3:0]  arg_k_q, arg_k_d;
  logic [3:0]  best_idx_q, best_idx_d;
  logic [31:0] best_score_q, best_score_d;
  logic        cls_valid_q, cls_valid_d;
  logic [3:0]  cls_idx_q, cls_idx_d;
  logic [31:0] cls_score_q, cls_score_d;
  logic [31:0] arg_cand;

  assign arg_cand = score_q[{arg_k_q, 5'b0} +: 32];
`endif

  assign ld_ready = (state_q == S_IDLE) && (ld_count_q < LD_FULL);
  assign ld_fire  = ld_valid && ld_ready;
  assign start_ok = cmd_start && !cmd_clear && (state_q == S_IDLE) && (ld_count_q == LD_FULL);
  // The first two RUN cycles ignore acc_ready: the accelerator may still show a stale stop flag.
  assign acc_hit  = (state_q == S_RUN) && acc_ready && (cyc_q >= CYC_GUARD);
  assign res_fire = res_valid && res_ready;

  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    cyc_d      = cyc_q;
    score_d    = score_q;
    res_idx_d  = res_idx_q;
    err_d      = err_q;
`ifdef ACCEL_SEQ_ARGMAX_EN
    arg_k_d      = arg_k_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    cls_valid_d  = cls_valid_q;
    cls_idx_d    = cls_idx_q;
    cls_score_d  = cls_score_q;
`endif
    if (cmd_clear) begin
      state_d    = S_IDLE;
      ld_count_d = '0;
      res_idx_d  = '0;
`ifdef ACCEL_SEQ_ARGMAX_EN
      cls_valid_d = 1'b0;
      cls_idx_d   = '0;
      cls_score_d = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ld_fire) ld_count_d = ld_count_q + LD_ONE;
          if (start_ok) begin
            state_d = S_RUN;
            cyc_d   = '0;
            err_d   = 1'b0;
`ifdef ACCEL_SEQ_ARGMAX_EN
            cls_valid_d = 1'b0;
            cls_idx_d   = '0;
            cls_score_d = '0;
`endif
          end
        end
        S_RUN: begin
          cyc_d = cyc_q + CYC_ONE;
          if (acc_hit) begin
            score_d   = acc_result;
            res_idx_d = '0;
`ifdef ACCEL_SEQ_ARGMAX_EN
            state_d = S_ARGMAX;
            arg_k_d = '0;
`else
            state_d = S_DRAIN;
`endif
          end else if (cyc_q == CYC_LAST) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            ld_count_d = '0;
          end
        end
`ifdef ACCEL_SEQ_ARGMAX_EN
        // Strict greater-than keeps the lowest index on ties.
        S_ARGMAX: begin
          arg_k_d = arg_k_q + 4'd1;
          if ((arg_k_q == 4'd0) || ($signed(arg_cand) > $signed(best_score_q))) begin
            best_score_d = arg_cand;
            best_idx_d   = arg_k_q;
          end
          if (arg_k_q == 4'd9) begin
            state_d     = S_DRAIN;
            cls_valid_d = 1'b1;
            cls_idx_d   = best_idx_d;
            cls_score_d = best_score_d;
          end
        end
`endif
        S_DRAIN: begin
          if (res_fire) begin
            if (res_idx_q == 4'd9) begin
              state_d    = S_IDLE;
              ld_count_d = '0;
              res_idx_d  = '0;
            end else begin
              res_idx_d = res_idx_q + 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      ld_count_q  <= '0;
      cyc_q       <= '0;
      score_q     <= '0;
      res_idx_q   <= '0;
      err_q       <= 1'b0;
      acc_reset_q <= 1'b1;
`ifdef ACCEL_SEQ_ARGMAX_EN
      arg_k_q      <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      cls_valid_q  <= 1'b0;
      cls_idx_q    <= '0;
      cls_score_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ld_count_q  <= ld_count_d;
      cyc_q       <= cyc_d;
      score_q     <= score_d;
      res_idx_q   <= res_idx_d;
      err_q       <= err_d;
      acc_reset_q <= (state_d == S_IDLE);
`ifdef ACCEL_SEQ_ARGMAX_EN
      arg_k_q      <= arg_k_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      cls_valid_q  <= cls_valid_d;
      cls_idx_q    <= cls_idx_d;
      cls_score_q  <= cls_score_d;
`endif
    end
  end

  // Image storage survives reset and clear; only the fill count is reset.
  always_ff @(posedge clk) begin
    if (ld_fire) img_buf[ld_count_q[IDX_W-1:0]] <= ld_data;
  end

  assign acc_image   = (acc_counter1 < N_WORDS_W) ? img_buf[acc_counter1[IDX_W-1:0]] : 32'd0;
  assign acc_reset   = acc_reset_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;
  assign res_valid   = (state_q == S_DRAIN);
  assign res_idx     = res_idx_q;
  assign res_data    = res_valid ? score_q[{res_idx_q, 5'b0} +: 32] : 32'd0;
  assign res_last    = res_valid && (res_idx_q == 4'd9);

`ifdef ACCEL_SEQ_ARGMAX_EN
  assign class_valid = cls_valid_q;
  assign class_idx   = cls_idx_q;
  assign class_score = cls_score_q;
`else
  assign class_valid = 1'b0;
  assign class_idx   = 4'd0;
  assign class_score = 32'd0;
`endif
endmodule

// File: tb/tb_accel_seq.sv
// Randomized scoreboard bench for accel_seq; the score stream is checked by an
// independent monitor against expectations pushed when each result is issued.
`timescale 1ns/1ps
module tb_accel_seq;
  localparam int NW = 784;
  localparam int TO = 4096;
`ifdef ACCEL_SEQ_ARGMAX_EN
  localparam int EXP_LAT = 10;
`else
  localparam int EXP_LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         cmd_start, cmd_clear, ld_valid, ld_ready;
  logic [31:0]  ld_data;
  logic         acc_reset;
  logic [31:0]  acc_image, acc_counter1;
  logic         acc_ready;
  logic [319:0] acc_result;
  logic         res_valid, res_ready, res_last;
  logic [31:0]  res_data;
  logic [3:0]   res_idx;
  logic         class_valid;
  logic [3:0]   class_idx;
  logic [31:0]  class_score;
  logic         busy, err_timeout;

  accel_seq dut (
    .clk(clk), .resetn(resetn), .cmd_start(cmd_start), .cmd_clear(cmd_clear),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .acc_reset(acc_reset), .acc_image(acc_image), .acc_counter1(acc_counter1),
    .acc_ready(acc_ready), .acc_result(acc_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last),
    .class_valid(class_valid), .class_idx(class_idx), .class_score(class_score),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        last;
  } res_t;

  res_t        expQ[$];
  res_t        monExp;
  logic [31:0] img [NW];
  int          ldCount;
  int          vectors = 0;
  int          miscompares = 0;
  logic        stallPrev = 1'b0;
  logic [3:0]  stallIdx;
  logic [31:0] stallData;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per handshake and checks stall stability.
  always @(negedge clk) begin
    if (!resetn) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev && res_valid) begin
        checkOutput("stall_idx", {28'd0, res_idx}, {28'd0, stallIdx});
        checkOutput("stall_data", res_data, stallData);
      end
      if (res_valid && res_ready) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_result: got idx %0d, expected none", res_idx);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("res_idx", {28'd0, res_idx}, {28'd0, monExp.idx});
          checkOutput("res_data", res_data, monExp.data);
          checkOutput("res_last", {31'd0, res_last}, {31'd0, monExp.last});
        end
      end
      stallPrev = res_valid && !res_ready;
      stallIdx  = res_idx;
      stallData = res_data;
    end
  end

  task automatic loadImage(input int n, input bit ramp);
    for (int i = 0; i < n; i++) begin
      if (!ramp) while ($urandom_range(0, 3) == 0) tick();
      ld_valid = 1'b1;
      ld_data  = ramp ? 32'(ldCount) : $urandom();
      checkOutput("ld_ready_open", {31'd0, ld_ready}, 32'd1);
      img[ldCount] = ld_data;
      ldCount++;
      tick();
      ld_valid = 1'b0;
    end
  endtask

  task automatic loadFull(input bit ramp);
    ldCount = 0;
    loadImage(NW, ramp);
    checkOutput("ld_ready_full", {31'd0, ld_ready}, 32'd0);
  endtask

  task automatic startRun();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    checkOutput("start_acc_reset", {31'd0, acc_reset}, 32'd0);
    checkOutput("start_busy", {31'd0, busy}, 32'd1);
    checkOutput("start_err_clr", {31'd0, err_timeout}, 32'd0);
    checkOutput("start_class_clr", {31'd0, class_valid}, 32'd0);
  endtask

  task automatic sweep();
    logic [31:0] extra [4];
    extra[0] = 32'd784;
    extra[1] = 32'd1029;
    extra[2] = 32'h8000_0003;
    extra[3] = 32'd1023;
    for (int c = 0; c < NW + 4; c++) begin
      acc_counter1 = (c < NW) ? 32'(c) : extra[c - NW];
      #1;
      checkOutput("acc_image", acc_image, (c < NW) ? img[c] : 32'd0);
      tick();
    end
    acc_counter1 = 32'd0;
  endtask

  task automatic capture(input int sc[10]);
    int best;
    int lat;
    best = 0;
    for (int k = 1; k < 10; k++) if (sc[k] > sc[best]) best = k;
    for (int k = 0; k < 10; k++) begin
      expQ.push_back('{idx: 4'(k), data: sc[k], last: (k == 9)});
      acc_result[32*k +: 32] = sc[k];
    end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    for (int k = 0; k < 10; k++) acc_result[32*k +: 32] = $urandom();
    lat = 0;
    while (!res_valid && lat < 50) begin
      tick();
      lat++;
    end
    checkOutput("capture_latency", 32'(lat), 32'(EXP_LAT));
`ifdef ACCEL_SEQ_ARGMAX_EN
    checkOutput("class_valid", {31'd0, class_valid}, 32'd1);
    checkOutput("class_idx", {28'd0, class_idx}, 32'(best));
    checkOutput("class_score", class_score, sc[best]);
`else
    checkOutput("class_valid_off", {31'd0, class_valid}, 32'd0);
    checkOutput("class_idx_off", {28'd0, class_idx}, 32'd0);
    checkOutput("class_score_off", class_score, 32'd0);
`endif
  endtask

  task automatic drain(input int mode, output int cycles);
    int n;
    n = 0;
    while (busy && n < 200) begin
      case (mode)
        0:       res_ready = 1'b1;
        1:       res_ready = ((n % 4) == 0) || ((n % 4) == 3);
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
    end
    res_ready = 1'b0;
    cycles = n;
    checkOutput("drain_done", {31'd0, busy}, 32'd0);
    checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("drain_acc_reset", {31'd0, acc_reset}, 32'd1);
    checkOutput("drain_ld_ready", {31'd0, ld_ready}, 32'd1);
    checkOutput("drain_res_valid", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic applyStimulus(input int scoreMode, output int sc[10]);
    for (int k = 0; k < 10; k++)
      sc[k] = (scoreMode == 0) ? $urandom_range(0, 6) - 3 : int'($urandom());
  endtask

  task automatic checkIdleAfterAbort(input string tag);
    checkOutput({tag, "_acc_reset"}, {31'd0, acc_reset}, 32'd1);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    checkOutput({tag, "_class_valid"}, {31'd0, class_valid}, 32'd0);
    checkOutput({tag, "_ld_ready"}, {31'd0, ld_ready}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc[10];
    int cyc;
    int n;
    resetn = 1'b0; cmd_start = 1'b0; cmd_clear = 1'b0; ld_valid = 1'b0; ld_data = '0;
    acc_counter1 = '0; acc_ready = 1'b0; acc_result = '0; res_ready = 1'b0;
    repeat (3) tick();
    checkIdleAfterAbort("reset");
    checkOutput("reset_err", {31'd0, err_timeout}, 32'd0);
    checkOutput("reset_res_idx", {28'd0, res_idx}, 32'd0);
    checkOutput("reset_res_data", res_data, 32'd0);
    checkOutput("reset_res_last", {31'd0, res_last}, 32'd0);
    checkOutput("reset_class_idx", {28'd0, class_idx}, 32'd0);
    checkOutput("reset_class_score", class_score, 32'd0);
    resetn = 1'b1;
    tick();

    // Partial image: start must be ignored.
    ldCount = 0;
    loadImage(500, 1'b1);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    checkOutput("short_start_busy", {31'd0, busy}, 32'd0);
    checkOutput("short_start_ld_ready", {31'd0, ld_ready}, 32'd1);
    checkOutput("short_start_acc_reset", {31'd0, acc_reset}, 32'd1);
    loadImage(NW - 500, 1'b1);
    checkOutput("ld_ready_full", {31'd0, ld_ready}, 32'd0);

    // Inference 1: ramp image, fixed scores, stale acc_ready in first RUN cycles.
    startRun();
    for (int k = 0; k < 10; k++) acc_result[32*k +: 32] = $urandom();
    acc_ready = 1'b1;
    tick();
    tick();
    acc_ready = 1'b0;
    sweep();
    checkOutput("stale_ready_ignored", {31'd0, res_valid}, 32'd0);
    checkOutput("stale_ready_busy", {31'd0, busy}, 32'd1);
    sc = '{5, -3, 9, 9, 0, 1, 2, 3, 4, -8};
    capture(sc);
    drain(0, cyc);
    checkOutput("drain_cycles", 32'(cyc), 32'd10);
`ifdef ACCEL_SEQ_ARGMAX_EN
    checkOutput("class_held", {31'd0, class_valid}, 32'd1);
`endif

    // Inference 2: random image, tie-heavy scores, ready pattern 1,0,0,1.
    loadFull(1'b0);
    startRun();
    sweep();
    applyStimulus(0, sc);
    capture(sc);
    drain(1, cyc);

    // Inference 3: capture on the first eligible RUN cycle, full-range signed scores.
    loadFull(1'b0);
    startRun();
    for (int k = 0; k < 10; k++) acc_result[32*k +: 32] = $urandom();
    acc_ready = 1'b1;
    tick();
    tick();
    applyStimulus(1, sc);
    capture(sc);
    drain(2, cyc);

    // Timeout: acc_ready never arrives.
    loadFull(1'b0);
    startRun();
    n = 0;
    while (busy && n < TO + 100) begin
      tick();
      n++;
    end
    checkOutput("timeout_cycles", 32'(n), 32'(TO));
    checkOutput("timeout_err", {31'd0, err_timeout}, 32'd1);
    checkIdleAfterAbort("timeout");
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    checkOutput("clear_keeps_err", {31'd0, err_timeout}, 32'd1);

    // cmd_clear during DRAIN at index 4 (startRun checks err_timeout clears).
    loadFull(1'b0);
    startRun();
    repeat (3) tick();
    applyStimulus(1, sc);
    capture(sc);
    n = 0;
    res_ready = 1'b1;
    while (res_idx != 4'd4 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("clear_reached_idx4", {28'd0, res_idx}, 32'd4);
    res_ready = 1'b0;
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
    expQ.delete();
    checkIdleAfterAbort("clear");

    // Asynchronous reset in the middle of RUN.
    loadFull(1'b0);
    startRun();
    repeat (5) tick();
    #2;
    resetn = 1'b0;
    #1;
    checkIdleAfterAbort("async_reset");
    checkOutput("async_reset_err", {31'd0, err_timeout}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

    // Normal operation after reset.
    loadFull(1'b0);
    startRun();
    repeat (4) tick();
    applyStimulus(0, sc);
    capture(sc);
    drain(0, cyc);
    checkOutput("final_drain_cycles", 32'(cyc), 32'd10);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/accel_seq.md
# accel_seq

Sequencer for the MNIST NN accelerator:
- Holds the accelerator in reset while the host loads one image into a local buffer.
- Releases reset on a start command and feeds the accelerator's image port from the buffer, indexed by the accelerator's own pixel counter.
- When the accelerator reports ready, captures the 10 class scores, computes the argmax, and returns the scores one at a time over a valid/ready stream.
- Sits between the picoRV32 peripheral bus glue and the accelerator instance.

## Interface
- N_WORDS, 784: image words per inference.
- IDX_W, 10: buffer index width; must satisfy 2^IDX_W >= N_WORDS.
- TIMEOUT, 4096: maximum RUN cycles before abort.
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle pulse; starts an inference.
- cmd_clear  in  1  one-cycle pulse; aborts and empties the buffer.
- ld_valid  in  1  host image-word valid.
- ld_ready  out  1  buffer accepts a word.
- ld_data  in  32  image word; words are loaded in pixel order.
- acc_reset  out  1  active-high reset to the accelerator; registered.
- acc_image  out  32  image word presented to the accelerator.
- acc_counter1  in  32  accelerator pixel counter.
- acc_ready  in  1  accelerator done.
- acc_result  in  320  packed scores; result k occupies bits [32k+31:32k].
- res_valid  out  1  score stream valid.
- res_ready  in  1  score stream ready.
- res_data  out  32  score.
- res_idx  out  4  class index of res_data.
- res_last  out  1  high with res_idx==9.
- class_valid  out  1  argmax result valid.
- class_idx  out  4  winning class.
- class_score  out  32  winning score.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky timeout flag.

## Operation
States and transitions:
- IDLE: acc_reset=1. ld_ready=1 while ld_count<N_WORDS. Each ld handshake writes buf[ld_count] and increments ld_count.
- IDLE -> RUN: cmd_start while ld_count==N_WORDS. A start with ld_count<N_WORDS is ignored.
- RUN: acc_reset=0. acc_image = buf[acc_counter1[IDX_W-1:0]] combinationally; acc_image=0 when acc_counter1>=N_WORDS. acc_ready is ignored during the first 2 RUN cycles (guard against stale stop flags).
- RUN -> ARGMAX: first valid acc_ready. All 10 scores are latched into internal regs on that edge.
- RUN -> IDLE: the run-cycle counter reaches TIMEOUT. err_timeout is set and ld_count cleared.
- ARGMAX: one signed 32-bit compare per cycle over k=0..9. The best score updates only on strict greater-than, so ties go to the lowest index. Lasts 10 cycles, then DRAIN.
- DRAIN: presents scores k=0..9 in order. res_idx/res_data advance only on a res_valid&res_ready handshake. The handshake at k=9 goes to IDLE, clears ld_count and reasserts acc_reset.

Other rules:
- class_valid/class_idx/class_score are set on leaving ARGMAX and held until the next accepted cmd_start or cmd_clear.
- cmd_clear in any state: go to IDLE, acc_reset=1 next edge, ld_count=0, class_valid=0, res_valid=0. err_timeout is not cleared.
- err_timeout is cleared only by resetn or an accepted cmd_start.
- cmd_start outside IDLE is ignored. If cmd_clear and cmd_start are asserted together, clear wins.
- The buffer contents are not reset; only ld_count is.

Reset values (resetn low):
- state=IDLE, acc_reset=1, ld_count=0.
- res_valid=0, res_idx=0, res_data=0, res_last=0.
- class_valid=0, class_idx=0, class_score=0.
- err_timeout=0, busy=0, ld_ready=1.

## Timing
- Load: one word per cycle sustained; ld_ready drops the cycle after the N_WORDS-th handshake.
- Start: accepted at edge t. acc_reset=0 and busy=1 from t+1.
- Image path: acc_image has zero-cycle latency from acc_counter1.
- Capture: acc_ready seen at edge r. ARGMAX spans r+1..r+10. class_valid=1 and res_valid=1 (k=0) from r+11.
- Stream: with res_ready held high, one score per cycle. The last handshake is at r+20; acc_reset=1 and ld_ready=1 from r+21.
- Reset: resetn assertion mid-operation forces reset values immediately (asynchronously). After deassertion, the first active edge is in IDLE.

## Configuration
- ACCEL_SEQ_ARGMAX_EN defined: ARGMAX state and class_* outputs are as specified above.
- ACCEL_SEQ_ARGMAX_EN undefined:
  - ARGMAX state is removed; RUN goes directly to DRAIN, so res_valid is asserted from r+1.
  - class_valid, class_idx and class_score are tied to 0.

## Test plan
- Load 784 words (word i = i), pulse start, acc_counter1 sweeps 0..783 -> acc_image equals acc_counter1 each cycle; acc_reset falls 1 cycle after start.
- Scores {5,-3,9,9,0,1,2,3,4,-8}, acc_ready at r -> class_idx=2, class_score=9 at r+11; stream returns the 10 scores in order; res_last only at idx 9.
- Start after only 500 loaded words -> ignored: busy stays 0, ld_ready stays 1.
- acc_ready never asserts -> after 4096 RUN cycles err_timeout=1, state IDLE, ld_count=0; next accepted start clears err_timeout.
- Drain with res_ready toggling 1,0,0,1 -> each index held stable while stalled; no index skipped or repeated.
- cmd_clear during DRAIN at idx 4, and resetn pulse during RUN -> both return to IDLE with acc_reset=1 and res_valid=0; class_valid=0.
